// File: rtl/llc_pipe_ctrl_pkg.sv
// LLC pipeline control: shared cache set type, FSM states and
// the saturating helper used by the conflict stall counter.
package llc_pipe_ctrl_pkg;

    localparam int LLC_SET_BITS = 8;

    typedef logic [LLC_SET_BITS-1:0] llc_set_t;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SERIAL = 2'd2
    } llc_fsm_e;

    localparam logic [15:0] CONFLICT_CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == CONFLICT_CNT_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/llc_set_conflict.sv
// Flags an incoming request whose set is still owned by any
// valid stage of the LLC pipeline.
module llc_set_conflict
    import llc_pipe_ctrl_pkg::*;
(
    input  logic [LLC_SET_BITS-1:0] issue_set_i,
    input  logic [3:0]              stage_v_i,
    input  logic [LLC_SET_BITS-1:0] set_mem_i,
    input  logic [LLC_SET_BITS-1:0] set_look_i,
    input  logic [LLC_SET_BITS-1:0] set_proc_i,
    input  logic [LLC_SET_BITS-1:0] set_upd_i,
    output logic                    conflict_o
);

    logic [3:0] hit;

    assign hit[0] = stage_v_i[0] & (issue_set_i == set_mem_i);
    assign hit[1] = stage_v_i[1] & (issue_set_i == set_look_i);
    assign hit[2] = stage_v_i[2] & (issue_set_i == set_proc_i);
    assign hit[3] = stage_v_i[3] & (issue_set_i == set_upd_i);

    assign conflict_o = |hit;

endmodule

// File: rtl/llc_pipe_ctrl.sv
// LLC request pipeline control: mem -> lookup -> proc -> update,
// with set-conflict stalls and a drain-then-serialise mode.
module llc_pipe_ctrl
    import llc_pipe_ctrl_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue_valid,
    input  logic                    issue_serial,
    input  logic [LLC_SET_BITS-1:0] issue_set,
    output logic                    issue_ready,
    input  logic                    process_done,
    output logic                    fifo_push_mem,
    output logic                    fifo_pop_mem,
    output logic                    fifo_push_lookup,
    output logic                    fifo_pop_lookup,
    output logic                    fifo_push_proc,
    output logic                    fifo_pop_proc,
    output logic                    mem_rd_en,
    output logic                    update_en,
    output logic                    pipe_empty,
    output logic [15:0]             conflict_cnt
);

    logic v_mem_q, v_look_q, v_proc_q, v_upd_q;
    logic v_mem_d, v_look_d, v_proc_d, v_upd_d;

    llc_set_t set_mem_q, set_look_q, set_proc_q, set_upd_q;

    llc_fsm_e    state_q, state_d;
    logic [15:0] cnt_q, cnt_d;

    logic conflict;
    logic proc_adv, look_adv, mem_adv, mem_free;
    logic ready, accept, conflict_stall;

    llc_set_conflict u_conflict (
        .issue_set_i (issue_set),
        .stage_v_i   ({v_upd_q, v_proc_q, v_look_q, v_mem_q}),
        .set_mem_i   (set_mem_q),
        .set_look_i  (set_look_q),
        .set_proc_i  (set_proc_q),
        .set_upd_i   (set_upd_q),
        .conflict_o  (conflict)
    );

    // Each stage moves when the stage ahead is empty or moving itself.
    assign proc_adv = v_proc_q & process_done;
    assign look_adv = v_look_q & (!v_proc_q | proc_adv);
    assign mem_adv  = v_mem_q & (!v_look_q | look_adv);
    assign mem_free = !v_mem_q | mem_adv;

    assign pipe_empty = !(v_mem_q | v_look_q | v_proc_q | v_upd_q);

    always_comb begin
        ready   = 1'b0;
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                ready = issue_serial ? pipe_empty : (!conflict & mem_free);
                if (issue_valid & issue_serial) begin
                    state_d = pipe_empty ? ST_SERIAL : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                ready = pipe_empty;
                if (!issue_valid) begin
                    state_d = ST_RUN;
                end else if (pipe_empty) begin
                    state_d = ST_SERIAL;
                end
            end
            ST_SERIAL: begin
                if (v_upd_q) begin
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    assign issue_ready = ready & rst;
    assign accept      = issue_valid & issue_ready;

    assign conflict_stall = issue_valid & (state_q == ST_RUN) & !issue_serial
                          & mem_free & conflict;

    assign cnt_d = conflict_stall ? sat_inc16(cnt_q) : cnt_q;

    assign v_mem_d  = accept | (v_mem_q & !mem_adv);
    assign v_look_d = mem_adv | (v_look_q & !look_adv);
    assign v_proc_d = look_adv | (v_proc_q & !proc_adv);
    assign v_upd_d  = proc_adv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_mem_q    <= 1'b0;
            v_look_q   <= 1'b0;
            v_proc_q   <= 1'b0;
            v_upd_q    <= 1'b0;
            set_mem_q  <= '0;
            set_look_q <= '0;
            set_proc_q <= '0;
            set_upd_q  <= '0;
            state_q    <= ST_RUN;
            cnt_q      <= '0;
        end else begin
            v_mem_q  <= v_mem_d;
            v_look_q <= v_look_d;
            v_proc_q <= v_proc_d;
            v_upd_q  <= v_upd_d;
            if (accept)   set_mem_q  <= issue_set;
            if (mem_adv)  set_look_q <= set_mem_q;
            if (look_adv) set_proc_q <= set_look_q;
            if (proc_adv) set_upd_q  <= set_proc_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign fifo_push_mem    = accept;
    assign mem_rd_en        = accept;
    assign fifo_pop_mem     = mem_adv;
    assign fifo_push_lookup = mem_adv;
    assign fifo_pop_lookup  = look_adv;
    assign fifo_push_proc   = look_adv;
    assign fifo_pop_proc    = proc_adv;
    assign update_en        = v_upd_q;
    assign conflict_cnt     = cnt_q;

endmodule
